// File: rtl/sobel_gradient_core.sv
// Sobel/Prewitt gradient magnitude on a 3x3 window, one result per 8 cycles.
// Sequenced by an eight-state FSM with a saturating edge counter.
module sobel_gradient_core #(
    parameter int PIXEL_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [9*PIXEL_W-1:0]   i_window,
    input  logic                   i_kernel_sel,
    input  logic                   i_mag_sel,
    input  logic [PIXEL_W-1:0]     i_threshold,
    input  logic                   i_count_clear,
    output logic                   o_busy,
    output logic                   o_data_ready,
    output logic [PIXEL_W-1:0]     o_processed_sum,
    output logic                   o_edge,
    output logic [CNT_W-1:0]       o_edge_count
);

    localparam int GW = PIXEL_W + 3;
    localparam int AW = PIXEL_W + 2;

    typedef enum logic [2:0] {
        IDLE, CAPTURE, CALC_X, CALC_Y, ABS, COMBINE, CLAMP, DONE
    } state_t;

    state_t state;

    logic [9*PIXEL_W-1:0] win_q;
    logic                 ksel_q;
    logic                 msel_q;
    logic [PIXEL_W-1:0]   thr_q;
    logic signed [GW-1:0] gx_q;
    logic signed [GW-1:0] gy_q;
    logic [AW-1:0]        ax_q;
    logic [AW-1:0]        ay_q;
    logic [GW-1:0]        comb_q;

    logic signed [GW-1:0] px [9];
    logic signed [GW-1:0] dx;
    logic signed [GW-1:0] dy;
    logic signed [GW-1:0] gx_c;
    logic signed [GW-1:0] gy_c;
    logic [AW-1:0]        ax_c;
    logic [AW-1:0]        ay_c;
    logic [AW-1:0]        max_c;
    logic [GW-1:0]        comb_c;
    logic [PIXEL_W-1:0]   clamp_c;
    logic                 edge_c;

    // Pixels are zero-extended so every difference stays exact in GW bits.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            px[k] = $signed({3'b000, win_q[k*PIXEL_W +: PIXEL_W]});
        end
        dx   = px[5] - px[3];
        dy   = px[1] - px[7];
        gx_c = (px[2] - px[0]) + (ksel_q ? dx : dx <<< 1)
             + (px[8] - px[6]);
        gy_c = (px[0] - px[6]) + (ksel_q ? dy : dy <<< 1)
             + (px[2] - px[8]);
        ax_c = AW'(gx_q[GW-1] ? -gx_q : gx_q);
        ay_c = AW'(gy_q[GW-1] ? -gy_q : gy_q);
        max_c  = (ax_q > ay_q) ? ax_q : ay_q;
        comb_c = msel_q ? {1'b0, max_c}
                        : ({1'b0, ax_q} + {1'b0, ay_q});
        clamp_c = (|comb_q[GW-1:PIXEL_W]) ? '1
                                          : comb_q[PIXEL_W-1:0];
        edge_c  = (clamp_c >= thr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            win_q           <= '0;
            ksel_q          <= 1'b0;
            msel_q          <= 1'b0;
            thr_q           <= '0;
            gx_q            <= '0;
            gy_q            <= '0;
            ax_q            <= '0;
            ay_q            <= '0;
            comb_q          <= '0;
            o_data_ready    <= 1'b0;
            o_processed_sum <= '0;
            o_edge          <= 1'b0;
        end else begin
            o_data_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        win_q  <= i_window;
                        ksel_q <= i_kernel_sel;
                        msel_q <= i_mag_sel;
                        thr_q  <= i_threshold;
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: state <= CALC_X;
                CALC_X: begin
                    gx_q  <= gx_c;
                    state <= CALC_Y;
                end
                CALC_Y: begin
                    gy_q  <= gy_c;
                    state <= ABS;
                end
                ABS: begin
                    ax_q  <= ax_c;
                    ay_q  <= ay_c;
                    state <= COMBINE;
                end
                COMBINE: begin
                    comb_q <= comb_c;
                    state  <= CLAMP;
                end
                CLAMP: begin
                    o_processed_sum <= clamp_c;
                    o_edge          <= edge_c;
                    o_data_ready    <= 1'b1;
                    state           <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Clear wins over a coincident increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_edge_count <= '0;
        end else if (i_count_clear) begin
            o_edge_count <= '0;
        end else if (state == CLAMP && edge_c && o_edge_count != '1) begin
            o_edge_count <= o_edge_count + 1'b1;
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_sobel_gradient_core.sv
// Directed bench for sobel_gradient_core: 16-bit and 2-bit counter
// instances share stimulus; expected values are hand-computed.
module tb_sobel_gradient_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [71:0] i_window;
    logic        i_kernel_sel;
    logic        i_mag_sel;
    logic [7:0]  i_threshold;
    logic        i_count_clear;

    logic        o_busy, o_data_ready, o_edge;
    logic [7:0]  o_processed_sum;
    logic [15:0] o_edge_count;
    logic        o_busy2, o_data_ready2, o_edge2;
    logic [7:0]  o_processed_sum2;
    logic [1:0]  o_edge_count2;

    int n_assert = 0;
    int n_fail   = 0;
    int e16      = 0;
    int e2       = 0;

    always #5 clk = ~clk;

    sobel_gradient_core #(.PIXEL_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_window(i_window),
        .i_kernel_sel(i_kernel_sel), .i_mag_sel(i_mag_sel),
        .i_threshold(i_threshold), .i_count_clear(i_count_clear),
        .o_busy(o_busy), .o_data_ready(o_data_ready),
        .o_processed_sum(o_processed_sum), .o_edge(o_edge),
        .o_edge_count(o_edge_count)
    );

    sobel_gradient_core #(.PIXEL_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_window(i_window),
        .i_kernel_sel(i_kernel_sel), .i_mag_sel(i_mag_sel),
        .i_threshold(i_threshold), .i_count_clear(i_count_clear),
        .o_busy(o_busy2), .o_data_ready(o_data_ready2),
        .o_processed_sum(o_processed_sum2), .o_edge(o_edge2),
        .o_edge_count(o_edge_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [71:0] win9(
        input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
        input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5,
        input logic [7:0] p6, input logic [7:0] p7, input logic [7:0] p8);
        return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_result(input logic edge_v, input logic clr);
        if (clr) begin
            e16 = 0;
            e2  = 0;
        end else if (edge_v) begin
            if (e16 < 65535) e16++;
            if (e2 < 3) e2++;
        end
    endtask

    // One request; cycle c counts cycles after the accepting edge.
    task automatic run_op(input string tag, input logic [71:0] win,
                          input logic ksel, input logic msel,
                          input logic [7:0] thr, input logic [7:0] exp_sum,
                          input logic exp_edge, input logic clr);
        i_window     = win;
        i_kernel_sel = ksel;
        i_mag_sel    = msel;
        i_threshold  = thr;
        i_start      = 1'b1;
        tick();
        i_start      = 1'b0;
        i_window     = ~win;
        i_kernel_sel = ~ksel;
        i_mag_sel    = ~msel;
        i_threshold  = ~thr;
        for (int c = 1; c <= 8; c++) begin
            chk({tag, "/busy"}, o_busy, c != 8);
            chk({tag, "/ready"}, o_data_ready, c == 7);
            if (c == 7) begin
                model_result(exp_edge, clr);
                chk({tag, "/sum"}, o_processed_sum, exp_sum);
                chk({tag, "/edge"}, o_edge, exp_edge);
                chk({tag, "/cnt16"}, o_edge_count, e16);
                chk({tag, "/cnt2"}, o_edge_count2, e2);
            end
            if (c == 8) chk({tag, "/hold"}, o_processed_sum, exp_sum);
            if (c == 6) i_count_clear = clr;
            if (c < 8) begin
                tick();
                i_count_clear = 1'b0;
            end
        end
    endtask

    logic [71:0] w_flat, w_right, w_left, w_clamp, w_top;
    int          cnt_seq [6] = '{1, 2, 3, 3, 3, 0};

    initial begin
        w_flat  = win9(100, 100, 100, 100, 100, 100, 100, 100, 100);
        w_right = win9(0, 0, 20, 0, 0, 20, 0, 0, 20);
        w_left  = win9(50, 0, 0, 50, 0, 0, 50, 0, 0);
        w_clamp = win9(0, 0, 255, 0, 0, 255, 0, 0, 255);
        w_top   = win9(10, 20, 30, 0, 0, 0, 0, 0, 0);

        rst = 1'b1;
        i_start = 1'b0;
        i_window = '0;
        i_kernel_sel = 1'b0;
        i_mag_sel = 1'b0;
        i_threshold = '0;
        i_count_clear = 1'b0;
        tick();
        tick();
        chk("rst/busy", o_busy, 0);
        chk("rst/ready", o_data_ready, 0);
        chk("rst/sum", o_processed_sum, 0);
        chk("rst/edge", o_edge, 0);
        chk("rst/cnt16", o_edge_count, 0);
        chk("rst/cnt2", o_edge_count2, 0);
        rst = 1'b0;

        run_op("flat", w_flat, 0, 0, 8'd1, 8'd0, 0, 0);
        run_op("sobel", w_right, 0, 0, 8'd100, 8'd80, 0, 0);
        run_op("prewitt", w_right, 1, 0, 8'd60, 8'd60, 1, 0);
        run_op("max_sobel", w_right, 0, 1, 8'd81, 8'd80, 0, 0);
        run_op("top_sum", w_top, 0, 0, 8'd50, 8'd100, 1, 0);
        run_op("top_max", w_top, 0, 1, 8'd50, 8'd80, 1, 0);
        run_op("neg_thr", w_left, 0, 0, 8'd200, 8'd200, 1, 0);
        run_op("clamp", w_clamp, 0, 0, 8'd255, 8'd255, 1, 0);

        // i_start held high: busy 0,1x7 and a pulse every 8th cycle
        i_window = w_right;
        i_kernel_sel = 1'b0;
        i_mag_sel = 1'b0;
        i_threshold = 8'd50;
        i_start = 1'b1;
        for (int i = 0; i < 24; i++) begin
            chk("b2b/busy", o_busy, (i % 8) != 0);
            chk("b2b/ready", o_data_ready, (i % 8) == 7);
            if ((i % 8) == 7) begin
                model_result(1'b1, 1'b0);
                chk("b2b/sum", o_processed_sum, 80);
                chk("b2b/cnt16", o_edge_count, e16);
            end
            tick();
        end
        i_start = 1'b0;

        // reset pulse while in CALC_Y
        i_window = w_clamp;
        i_threshold = 8'd1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        chk("abort/busy_pre", o_busy, 1);
        rst = 1'b1;
        #1;
        chk("abort/busy", o_busy, 0);
        chk("abort/ready", o_data_ready, 0);
        chk("abort/sum", o_processed_sum, 0);
        chk("abort/edge", o_edge, 0);
        chk("abort/cnt16", o_edge_count, 0);
        chk("abort/cnt2", o_edge_count2, 0);
        tick();
        rst = 1'b0;
        e16 = 0;
        e2 = 0;
        for (int i = 0; i < 8; i++) begin
            chk("abort/no_ready", o_data_ready, 0);
            chk("abort/idle", o_busy, 0);
            tick();
        end

        run_op("post_rst", w_left, 0, 0, 8'd200, 8'd200, 1, 0);

        i_count_clear = 1'b1;
        tick();
        i_count_clear = 1'b0;
        e16 = 0;
        e2 = 0;
        chk("clr/cnt16", o_edge_count, 0);
        chk("clr/cnt2", o_edge_count2, 0);

        for (int r = 0; r < 6; r++) begin
            run_op("sat", w_left, 0, 0, 8'd200, 8'd200, 1, r == 5);
            chk("sat/seq", o_edge_count2, cnt_seq[r]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
